// File: rtl/warp_sched_pkg.sv
// Shared types and constants for the warp issue scheduler.
// Contents: offer/push state enums, stall-counter width and a warp-id width helper.
package warp_sched_pkg;

   localparam int unsigned STALL_CNT_W = 16;

   typedef enum logic {IDLE, OFFER} offer_state_t;
   typedef enum logic {PUSH_IDLE, PUSH_RUN} push_state_t;

   // Warp-id width; at least one bit so single-bit selects stay legal.
   function automatic int unsigned wid(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin arbiter: finds the first requester after the last grant.
// Ports:
//   req_i   - per-warp request vector
//   last_i  - index of the most recent grant; the search starts at last_i+1
//   grant_o - one-hot grant
//   idx_o   - index of the granted warp
//   any_o   - some request was granted
module warp_rr_arbiter
   import warp_sched_pkg::*;
#(
   parameter int unsigned NUM_WARPS = 4,
   parameter int unsigned WID       = wid(NUM_WARPS)
) (
   input  logic [NUM_WARPS-1:0] req_i,
   input  logic [WID-1:0]       last_i,
   output logic [NUM_WARPS-1:0] grant_o,
   output logic [WID-1:0]       idx_o,
   output logic                 any_o
);

   logic [WID-1:0] cand;

   // Walk the ring once, starting just after the previous winner.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
         cand = WID'((32'(last_i) + i) % NUM_WARPS);
         if (!any_o && req_i[cand]) begin
            grant_o[cand] = 1'b1;
            idx_o         = cand;
            any_o         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/warp_issue_scheduler.sv
// N-warp issue scheduler for one compute unit.
// Tracks per-warp PC / in-flight / busy-mask / done, offers the next ready warp
// round-robin to fetch, retires decoded instructions and owns the push path.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   warp_enable                 - launched warps
//   issue_valid/warp/pc, issue_ready        - offer handshake to fetch
//   dec_*                       - decoder result for an in-flight warp
//   lsu_clear_*                 - LSU completion, clears busy-mask bits
//   matmul_done                 - push/pull unit finished the current matmul
//   push_active, push_warp, pause           - push-path ownership
//   all_busy, all_done          - status
//   stall_cnt                   - per-warp 16-bit stall counters
// Option macro WARP_SCHED_STALL_CNT_EN enables the stall counters; otherwise
// stall_cnt is tied to zero.
module warp_issue_scheduler
   import warp_sched_pkg::*;
#(
   parameter int unsigned NUM_WARPS  = 4,
   parameter int unsigned PC_WIDTH   = 8,
   parameter int unsigned MASK_WIDTH = 4,
   parameter int unsigned PC_STEP    = 2,
   parameter int unsigned START_PC   = 0,
   localparam int unsigned WID       = wid(NUM_WARPS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_WARPS-1:0]             warp_enable,
   input  logic                             issue_ready,
   output logic                             issue_valid,
   output logic [WID-1:0]                   issue_warp,
   output logic [PC_WIDTH-1:0]              issue_pc,
   input  logic                             dec_valid,
   input  logic [WID-1:0]                   dec_warp,
   input  logic                             dec_is_mem,
   input  logic [MASK_WIDTH-1:0]            dec_mask,
   input  logic                             dec_is_matmul,
   input  logic                             dec_is_exit,
   input  logic                             dec_branch_en,
   input  logic [PC_WIDTH-1:0]              dec_branch_target,
   input  logic                             lsu_clear_valid,
   input  logic [WID-1:0]                   lsu_clear_warp,
   input  logic [MASK_WIDTH-1:0]            lsu_clear_mask,
   input  logic                             matmul_done,
   output logic                             push_active,
   output logic [WID-1:0]                   push_warp,
   output logic                             pause,
   output logic                             all_busy,
   output logic                             all_done,
   output logic [STALL_CNT_W*NUM_WARPS-1:0] stall_cnt
);

   logic [PC_WIDTH-1:0]   pc_q   [NUM_WARPS];
   logic [PC_WIDTH-1:0]   pc_d   [NUM_WARPS];
   logic [MASK_WIDTH-1:0] busy_q [NUM_WARPS];
   logic [MASK_WIDTH-1:0] busy_d [NUM_WARPS];
   logic [NUM_WARPS-1:0]  inflight_q, inflight_d, done_q, done_d, ready;
   offer_state_t          offer_q, offer_d;
   push_state_t           push_q, push_d;
   logic [WID-1:0]        issue_warp_q, issue_warp_d, rr_q, rr_d, push_warp_q, push_warp_d;
   logic [PC_WIDTH-1:0]   issue_pc_q, issue_pc_d, pick_pc;

   logic                  accept, dec_hit, push_free, mm_accept, mm_replay, retire;
   logic [NUM_WARPS-1:0]  arb_req, arb_grant;
   logic [WID-1:0]        arb_last, arb_idx;
   logic                  arb_any;

   // Per-warp eligibility for the next offer.
   always_comb begin
      ready = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         ready[w] = warp_enable[w] & ~done_q[w] & ~inflight_q[w] & (busy_q[w] == '0)
                  & ~((push_q == PUSH_RUN) && (push_warp_q == WID'(w)));
      end
   end

   // The warp accepted this cycle is still "ready" in the flops; hide it and
   // restart the search after it.
   assign accept   = (offer_q == OFFER) & issue_ready;
   assign arb_req  = ready & ~(accept ? (NUM_WARPS'(1) << issue_warp_q) : '0);
   assign arb_last = accept ? issue_warp_q : rr_q;

   warp_rr_arbiter #(
      .NUM_WARPS (NUM_WARPS),
      .WID       (WID)
   ) u_arb (
      .req_i   (arb_req),
      .last_i  (arb_last),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   // PC of the picked warp (one-hot AND-OR mux).
   always_comb begin
      pick_pc = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         pick_pc |= arb_grant[w] ? pc_q[w] : '0;
      end
   end

   // A matmul that finds the push path held by another matmul is bounced for replay.
   assign dec_hit   = dec_valid & inflight_q[dec_warp];
   assign push_free = (push_q == PUSH_IDLE) | matmul_done;
   assign mm_accept = dec_hit & dec_is_matmul & push_free;
   assign mm_replay = dec_hit & dec_is_matmul & ~push_free;
   assign retire    = dec_hit & ~mm_replay;

   // Next-state: offer FSM, retire, LSU clear, push FSM.
   always_comb begin
      offer_d      = offer_q;
      push_d       = push_q;
      issue_warp_d = issue_warp_q;
      issue_pc_d   = issue_pc_q;
      rr_d         = rr_q;
      push_warp_d  = push_warp_q;
      inflight_d   = inflight_q;
      done_d       = done_q;
      pc_d         = pc_q;
      busy_d       = busy_q;

      case (offer_q)
         IDLE: begin
            if (arb_any) begin
               offer_d      = OFFER;
               issue_warp_d = arb_idx;
               issue_pc_d   = pick_pc;
            end
         end
         OFFER: begin
            if (issue_ready) begin
               rr_d                     = issue_warp_q;
               inflight_d[issue_warp_q] = 1'b1;
               if (arb_any) begin
                  issue_warp_d = arb_idx;
                  issue_pc_d   = pick_pc;
               end else begin
                  offer_d = IDLE;
               end
            end
         end
         default: offer_d = IDLE;
      endcase

      if (dec_hit) begin
         inflight_d[dec_warp] = 1'b0;
      end
      if (retire) begin
         if (dec_is_exit) begin
            done_d[dec_warp] = 1'b1;
         end else begin
            pc_d[dec_warp] = dec_branch_en ? dec_branch_target
                                           : pc_q[dec_warp] + PC_WIDTH'(PC_STEP);
         end
      end

      // Clear first so a same-cycle set of the same bit wins.
      if (lsu_clear_valid) begin
         busy_d[lsu_clear_warp] = busy_d[lsu_clear_warp] & ~lsu_clear_mask;
      end
      if (retire && dec_is_mem) begin
         busy_d[dec_warp] = busy_d[dec_warp] | dec_mask;
      end

      case (push_q)
         PUSH_IDLE: begin
            if (mm_accept) begin
               push_d      = PUSH_RUN;
               push_warp_d = dec_warp;
            end
         end
         PUSH_RUN: begin
            if (mm_accept) begin
               push_warp_d = dec_warp;
            end else if (matmul_done) begin
               push_d = PUSH_IDLE;
            end
         end
         default: push_d = PUSH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         offer_q      <= IDLE;
         push_q       <= PUSH_IDLE;
         issue_warp_q <= '0;
         issue_pc_q   <= PC_WIDTH'(START_PC);
         rr_q         <= WID'(NUM_WARPS - 1);
         push_warp_q  <= '0;
         inflight_q   <= '0;
         done_q       <= '0;
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            pc_q[w]   <= PC_WIDTH'(START_PC);
            busy_q[w] <= '0;
         end
      end else begin
         offer_q      <= offer_d;
         push_q       <= push_d;
         issue_warp_q <= issue_warp_d;
         issue_pc_q   <= issue_pc_d;
         rr_q         <= rr_d;
         push_warp_q  <= push_warp_d;
         inflight_q   <= inflight_d;
         done_q       <= done_d;
         pc_q         <= pc_d;
         busy_q       <= busy_d;
      end
   end

   assign issue_valid = (offer_q == OFFER);
   assign issue_warp  = issue_warp_q;
   assign issue_pc    = issue_pc_q;
   assign push_active = (push_q == PUSH_RUN);
   assign push_warp   = push_warp_q;
   assign pause       = push_active & (busy_q[push_warp_q] != '0);
   assign all_busy    = (|(warp_enable & ~done_q)) & ~(|ready);
   assign all_done    = (|warp_enable) & (&(done_q | ~warp_enable));

`ifdef WARP_SCHED_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_q [NUM_WARPS];

   // Saturating count of cycles a live warp could not be offered.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) stall_q[w] <= '0;
      end else begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (warp_enable[w] && !done_q[w] && !ready[w] && (stall_q[w] != '1)) begin
               stall_q[w] <= stall_q[w] + STALL_CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      stall_cnt = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         stall_cnt[w*STALL_CNT_W +: STALL_CNT_W] = stall_q[w];
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_warp_issue_scheduler.sv
module tb_warp_issue_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  warp_enable;
   logic        issue_ready;
   logic        issue_valid;
   logic [1:0]  issue_warp;
   logic [7:0]  issue_pc;
   logic        dec_valid;
   logic [1:0]  dec_warp;
   logic        dec_is_mem;
   logic [3:0]  dec_mask;
   logic        dec_is_matmul;
   logic        dec_is_exit;
   logic        dec_branch_en;
   logic [7:0]  dec_branch_target;
   logic        lsu_clear_valid;
   logic [1:0]  lsu_clear_warp;
   logic [3:0]  lsu_clear_mask;
   logic        matmul_done;
   logic        push_active;
   logic [1:0]  push_warp;
   logic        pause;
   logic        all_busy;
   logic        all_done;
   logic [63:0] stall_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   warp_issue_scheduler dut (
      .clk               (clk),
      .reset             (reset),
      .warp_enable       (warp_enable),
      .issue_ready       (issue_ready),
      .issue_valid       (issue_valid),
      .issue_warp        (issue_warp),
      .issue_pc          (issue_pc),
      .dec_valid         (dec_valid),
      .dec_warp          (dec_warp),
      .dec_is_mem        (dec_is_mem),
      .dec_mask          (dec_mask),
      .dec_is_matmul     (dec_is_matmul),
      .dec_is_exit       (dec_is_exit),
      .dec_branch_en     (dec_branch_en),
      .dec_branch_target (dec_branch_target),
      .lsu_clear_valid   (lsu_clear_valid),
      .lsu_clear_warp    (lsu_clear_warp),
      .lsu_clear_mask    (lsu_clear_mask),
      .matmul_done       (matmul_done),
      .push_active       (push_active),
      .push_warp         (push_warp),
      .pause             (pause),
      .all_busy          (all_busy),
      .all_done          (all_done),
      .stall_cnt         (stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dec_valid = 0; dec_warp = 0; dec_is_mem = 0; dec_mask = 0; dec_is_matmul = 0;
      dec_is_exit = 0; dec_branch_en = 0; dec_branch_target = 0;
      lsu_clear_valid = 0; lsu_clear_warp = 0; lsu_clear_mask = 0; matmul_done = 0;
   endtask

   // One decoder result for one cycle.
   task automatic retire(input logic [1:0] w, input logic mem, input logic [3:0] mask,
                         input logic mm, input logic ex, input logic br, input logic [7:0] tgt);
      dec_valid = 1; dec_warp = w; dec_is_mem = mem; dec_mask = mask; dec_is_matmul = mm;
      dec_is_exit = ex; dec_branch_en = br; dec_branch_target = tgt;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; warp_enable = 4'hF; issue_ready = 1;
      tick(); tick();
      total_cnt++; if ({issue_valid, issue_pc} !== {1'b0, 8'h00}) $display("FAIL reset_offer: got v=%b pc=%h, want v=0 pc=00", issue_valid, issue_pc); else pass_cnt++;
      total_cnt++; if ({push_active, pause, all_busy, all_done} !== 4'b0000) $display("FAIL reset_status: got %b, want 0000", {push_active, pause, all_busy, all_done}); else pass_cnt++;
      total_cnt++; if (stall_cnt !== 64'd0) $display("FAIL reset_stall: got %h, want 0", stall_cnt); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'(i), 8'h00}) $display("FAIL rr_offer%0d: got v=%b w=%0d pc=%h, want v=1 w=%0d pc=00", i, issue_valid, issue_warp, issue_pc, i); else pass_cnt++;
      end
      tick();
      issue_ready = 0;
      total_cnt++; if ({issue_valid, all_busy} !== 2'b01) $display("FAIL rr_no_repeat: got v=%b busy=%b, want v=0 busy=1", issue_valid, all_busy); else pass_cnt++;
   endtask

   task automatic test_lsu_busy();
      retire(2'd1, 1, 4'b0011, 0, 0, 0, 8'h00);
      total_cnt++; if (issue_valid !== 1'b0) $display("FAIL busy_no_offer: got v=%b, want 0", issue_valid); else pass_cnt++;
      retire(2'd2, 0, 4'b0000, 0, 0, 0, 8'h00);
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd2, 8'h02}) $display("FAIL busy_skip: got v=%b w=%0d pc=%h, want v=1 w=2 pc=02", issue_valid, issue_warp, issue_pc); else pass_cnt++;
      lsu_clear_valid = 1; lsu_clear_warp = 2'd1; lsu_clear_mask = 4'b0011;
      tick();
      idle_inputs();
      issue_ready = 1;
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd1, 8'h02}) $display("FAIL lsu_clear_offer: got v=%b w=%0d pc=%h, want v=1 w=1 pc=02", issue_valid, issue_warp, issue_pc); else pass_cnt++;
      tick();
      issue_ready = 0;
      // Same-cycle set and clear of one bit: set must win.
      lsu_clear_valid = 1; lsu_clear_warp = 2'd1; lsu_clear_mask = 4'b0100;
      retire(2'd1, 1, 4'b0100, 0, 0, 0, 8'h00);
      tick(); tick();
      total_cnt++; if (issue_valid !== 1'b0) $display("FAIL set_wins: got v=%b, want 0", issue_valid); else pass_cnt++;
      lsu_clear_valid = 1; lsu_clear_warp = 2'd1; lsu_clear_mask = 4'b0100;
      tick();
      idle_inputs();
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd1, 8'h04}) $display("FAIL set_wins_clear: got v=%b w=%0d pc=%h, want v=1 w=1 pc=04", issue_valid, issue_warp, issue_pc); else pass_cnt++;
   endtask

   task automatic test_matmul();
      retire(2'd0, 0, 4'b0000, 1, 0, 0, 8'h00);
      total_cnt++; if ({push_active, push_warp, pause} !== {1'b1, 2'd0, 1'b0}) $display("FAIL mm_accept: got act=%b w=%0d pause=%b, want act=1 w=0 pause=0", push_active, push_warp, pause); else pass_cnt++;
      retire(2'd2, 0, 4'b0000, 1, 0, 0, 8'h00);
      total_cnt++; if ({push_active, push_warp} !== {1'b1, 2'd0}) $display("FAIL mm_busy_hold: got act=%b w=%0d, want act=1 w=0", push_active, push_warp); else pass_cnt++;
      issue_ready = 1;
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd2, 8'h02}) $display("FAIL mm_replay_offer: got v=%b w=%0d pc=%h, want v=1 w=2 pc=02", issue_valid, issue_warp, issue_pc); else pass_cnt++;
      tick();
      issue_ready = 0;
      total_cnt++; if (issue_valid !== 1'b0) $display("FAIL mm_owner_excluded: got v=%b, want 0", issue_valid); else pass_cnt++;
      matmul_done = 1;
      retire(2'd2, 0, 4'b0000, 1, 0, 0, 8'h00);
      total_cnt++; if ({push_active, push_warp} !== {1'b1, 2'd2}) $display("FAIL mm_handover: got act=%b w=%0d, want act=1 w=2", push_active, push_warp); else pass_cnt++;
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd0, 8'h02}) $display("FAIL mm_owner_freed: got v=%b w=%0d pc=%h, want v=1 w=0 pc=02", issue_valid, issue_warp, issue_pc); else pass_cnt++;
   endtask

   task automatic test_hold_wrap();
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd0, 8'h02}) $display("FAIL hold_c%0d: got v=%b w=%0d pc=%h, want v=1 w=0 pc=02", i, issue_valid, issue_warp, issue_pc); else pass_cnt++;
      end
      issue_ready = 1;
      tick();
      issue_ready = 0;
      retire(2'd0, 0, 4'b0000, 0, 0, 1, 8'hFE);
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd0, 8'hFE}) $display("FAIL branch_pc: got v=%b w=%0d pc=%h, want v=1 w=0 pc=fe", issue_valid, issue_warp, issue_pc); else pass_cnt++;
      issue_ready = 1;
      tick();
      issue_ready = 0;
      retire(2'd0, 0, 4'b0000, 0, 0, 0, 8'h00);
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd0, 8'h00}) $display("FAIL pc_wrap: got v=%b w=%0d pc=%h, want v=1 w=0 pc=00", issue_valid, issue_warp, issue_pc); else pass_cnt++;
   endtask

   task automatic test_exit_reset();
      issue_ready = 1;
      tick();
      issue_ready = 0;
      // w2 is not in flight: this branch must be ignored.
      retire(2'd2, 0, 4'b0000, 0, 0, 1, 8'h55);
      retire(2'd0, 0, 4'b0000, 0, 1, 0, 8'h00);
      retire(2'd1, 0, 4'b0000, 0, 1, 0, 8'h00);
      retire(2'd3, 0, 4'b0000, 0, 1, 0, 8'h00);
      total_cnt++; if ({all_done, all_busy} !== 2'b01) $display("FAIL exit_partial: got done=%b busy=%b, want done=0 busy=1", all_done, all_busy); else pass_cnt++;
      matmul_done = 1;
      tick();
      idle_inputs();
      total_cnt++; if (push_active !== 1'b0) $display("FAIL push_release: got act=%b, want 0", push_active); else pass_cnt++;
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd2, 8'h04}) $display("FAIL ignored_dec: got v=%b w=%0d pc=%h, want v=1 w=2 pc=04", issue_valid, issue_warp, issue_pc); else pass_cnt++;
      issue_ready = 1;
      tick();
      issue_ready = 0;
      retire(2'd2, 0, 4'b0000, 0, 1, 0, 8'h00);
      tick();
      total_cnt++; if ({all_done, all_busy, issue_valid} !== 3'b100) $display("FAIL all_done: got done=%b busy=%b v=%b, want done=1 busy=0 v=0", all_done, all_busy, issue_valid); else pass_cnt++;
      // Bring up a push, then reset in the middle of it.
      reset = 1; tick(); tick(); reset = 0;
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc, all_done} !== {1'b1, 2'd0, 8'h00, 1'b0}) $display("FAIL reset_after_done: got v=%b w=%0d pc=%h done=%b, want v=1 w=0 pc=00 done=0", issue_valid, issue_warp, issue_pc, all_done); else pass_cnt++;
      issue_ready = 1;
      tick();
      issue_ready = 0;
      retire(2'd0, 0, 4'b0000, 1, 0, 0, 8'h00);
      total_cnt++; if (push_active !== 1'b1) $display("FAIL push_before_reset: got act=%b, want 1", push_active); else pass_cnt++;
      reset = 1;
      tick();
      total_cnt++; if ({push_active, issue_valid, issue_pc, all_done} !== {1'b0, 1'b0, 8'h00, 1'b0}) $display("FAIL reset_mid_push: got act=%b v=%b pc=%h done=%b, want 0 0 00 0", push_active, issue_valid, issue_pc, all_done); else pass_cnt++;
      reset = 0;
      tick();
      total_cnt++; if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 2'd0, 8'h00}) $display("FAIL pc_after_reset: got v=%b w=%0d pc=%h, want v=1 w=0 pc=00", issue_valid, issue_warp, issue_pc); else pass_cnt++;
   endtask

   task automatic test_stall_cnt();
`ifdef WARP_SCHED_STALL_CNT_EN
      issue_ready = 1;
      repeat (4) tick();
      issue_ready = 0;
      repeat (70000) tick();
      total_cnt++; if (stall_cnt[63:48] !== 16'hFFFF) $display("FAIL stall_sat: got %h, want ffff", stall_cnt[63:48]); else pass_cnt++;
`else
      issue_ready = 1;
      repeat (4) tick();
      issue_ready = 0;
      repeat (20) tick();
      total_cnt++; if (stall_cnt !== 64'd0) $display("FAIL stall_off: got %h, want 0", stall_cnt); else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_lsu_busy();
      test_matmul();
      test_hold_wrap();
      test_exit_reset();
      test_stall_cnt();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
